// File: rtl/tlb_unit.sv
// tlb_unit: joint TLB executing TLBP/TLBR/TLBWI/TLBWR plus one instruction and one data lookup per cycle.
// Define TLB_PAGEMASK_EN to store PageMask for variable page sizes; otherwise pages are fixed at 4 KB.
module tlb_unit #(
    parameter int TLB_NUM = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_type,
    output logic        busy,
    output logic        cmd_done,
    input  logic [31:0] cp0_index,
    input  logic [31:0] cp0_entry_hi,
    input  logic [31:0] cp0_entry_lo0,
    input  logic [31:0] cp0_entry_lo1,
    input  logic [31:0] cp0_page_mask,
    input  logic [31:0] cp0_random,
    output logic [31:0] index_out,
    output logic [31:0] entry_hi_out,
    output logic [31:0] entry_lo0_out,
    output logic [31:0] entry_lo1_out,
    output logic [31:0] page_mask_out,
    input  logic [31:0] inst_vaddr,
    input  logic [31:0] data_vaddr,
    input  logic        data_is_write,
    output logic [31:0] inst_paddr,
    output logic [31:0] data_paddr,
    output logic        inst_refill,
    output logic        inst_invalid,
    output logic        data_refill,
    output logic        data_invalid,
    output logic        data_modify,
    output logic        inst_cached,
    output logic        data_cached
);
    localparam int IW = $clog2(TLB_NUM);
    localparam logic [1:0] IDLE = 2'd0, PROBE = 2'd1, RESP = 2'd2;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [11:0] mask;
        logic [19:0] pfn0, pfn1;
        logic [2:0]  c0, c1;
        logic        d0, d1, v0, v1;
    } entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        refill, invalid, modify, cached;
    } xlat_t;

    entry_t             tlb [TLB_NUM];
    entry_t             wdata, rd;
    logic [TLB_NUM-1:0] present, probe_vec, inst_hit, data_hit, probe_hit;
    logic [1:0]         state;
    logic [IW-1:0]      widx, ridx;
    logic               accept, wr_en, unused;
    xlat_t              inst_x, data_x;

    function automatic logic hit(input entry_t e, input logic p, input logic [18:0] vpn2, input logic [7:0] asid);
        return p && ((e.vpn2 & ~{7'b0, e.mask}) == (vpn2 & ~{7'b0, e.mask})) && (e.g || e.asid == asid);
    endfunction

    function automatic logic [IW-1:0] first(input logic [TLB_NUM-1:0] v);
        first = '0;
        for (int i = TLB_NUM - 1; i >= 0; i--)
            if (v[i]) first = IW'(i);
    endfunction

    function automatic xlat_t xlate(input entry_t e, input logic found, input logic [31:0] va, input logic wr);
        logic [12:0] sel;
        logic        odd;
        logic [19:0] pfn, m;
        xlate = '0;
        // the even/odd select is the first vaddr bit above the (contiguous) mask
        sel = ~{1'b0, e.mask} & {e.mask, 1'b1};
        odd = |(va[24:12] & sel);
        pfn = odd ? e.pfn1 : e.pfn0;
        m   = {8'b0, e.mask};
        if (va[31:30] == 2'b10) begin
            xlate.paddr  = {3'b0, va[28:0]};
            xlate.cached = ~va[29];
        end else if (!found) begin
            xlate.refill = 1'b1;
        end else begin
            xlate.paddr   = {(pfn & ~m) | (va[31:12] & m), va[11:0]};
            xlate.cached  = (odd ? e.c1 : e.c0) == 3'd3;
            xlate.invalid = ~(odd ? e.v1 : e.v0);
            xlate.modify  = (odd ? e.v1 : e.v0) & wr & ~(odd ? e.d1 : e.d0);
        end
    endfunction

    always_comb begin
        inst_hit  = '0;
        data_hit  = '0;
        probe_hit = '0;
        for (int i = 0; i < TLB_NUM; i++) begin
            inst_hit[i]  = hit(tlb[i], present[i], inst_vaddr[31:13], cp0_entry_hi[7:0]);
            data_hit[i]  = hit(tlb[i], present[i], data_vaddr[31:13], cp0_entry_hi[7:0]);
            probe_hit[i] = hit(tlb[i], present[i], cp0_entry_hi[31:13], cp0_entry_hi[7:0]);
        end
    end

    always_comb begin
        wdata      = '0;
        wdata.vpn2 = cp0_entry_hi[31:13];
        wdata.asid = cp0_entry_hi[7:0];
        wdata.g    = cp0_entry_lo0[0] & cp0_entry_lo1[0];
`ifdef TLB_PAGEMASK_EN
        wdata.mask = cp0_page_mask[24:13];
`else
        wdata.mask = '0;
`endif
        wdata.pfn0 = cp0_entry_lo0[25:6];
        wdata.c0   = cp0_entry_lo0[5:3];
        wdata.d0   = cp0_entry_lo0[2];
        wdata.v0   = cp0_entry_lo0[1];
        wdata.pfn1 = cp0_entry_lo1[25:6];
        wdata.c1   = cp0_entry_lo1[5:3];
        wdata.d1   = cp0_entry_lo1[2];
        wdata.v1   = cp0_entry_lo1[1];
    end

    assign ridx   = cp0_index[IW-1:0];
    assign widx   = cmd_type[3] ? cp0_random[IW-1:0] : cp0_index[IW-1:0];
    assign rd     = present[ridx] ? tlb[ridx] : '0;
    assign accept = rst && state == IDLE && cmd_valid && $onehot(cmd_type);
    assign wr_en  = accept && (cmd_type[3] || cmd_type[2]);
    assign inst_x = xlate(tlb[first(inst_hit)], |inst_hit, inst_vaddr, 1'b0);
    assign data_x = xlate(tlb[first(data_hit)], |data_hit, data_vaddr, data_is_write);
    assign busy     = state != IDLE;
    assign cmd_done = state == RESP;
    assign unused = ^{cp0_index[31:IW], cp0_random[31:IW], cp0_entry_hi[12:8], cp0_entry_lo0[31:26],
                      cp0_entry_lo1[31:26], cp0_page_mask, inst_x.modify};

    always_ff @(posedge clk)
        if (wr_en) tlb[widx] <= wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            present       <= '0;
            probe_vec     <= '0;
            index_out     <= '0;
            entry_hi_out  <= '0;
            entry_lo0_out <= '0;
            entry_lo1_out <= '0;
            page_mask_out <= '0;
            inst_paddr    <= '0;
            data_paddr    <= '0;
            inst_refill   <= 1'b0;
            inst_invalid  <= 1'b0;
            inst_cached   <= 1'b0;
            data_refill   <= 1'b0;
            data_invalid  <= 1'b0;
            data_modify   <= 1'b0;
            data_cached   <= 1'b0;
        end else begin
            inst_paddr   <= inst_x.paddr;
            inst_refill  <= inst_x.refill;
            inst_invalid <= inst_x.invalid;
            inst_cached  <= inst_x.cached;
            data_paddr   <= data_x.paddr;
            data_refill  <= data_x.refill;
            data_invalid <= data_x.invalid;
            data_modify  <= data_x.modify;
            data_cached  <= data_x.cached;
            if (accept) begin
                state     <= cmd_type[0] ? PROBE : RESP;
                probe_vec <= probe_hit;
                if (wr_en) present[widx] <= 1'b1;
                if (cmd_type[1]) begin
                    entry_hi_out  <= {rd.vpn2 & ~{7'b0, rd.mask}, 5'b0, rd.asid};
                    entry_lo0_out <= {6'b0, rd.pfn0 & ~{8'b0, rd.mask}, rd.c0, rd.d0, rd.v0, rd.g};
                    entry_lo1_out <= {6'b0, rd.pfn1 & ~{8'b0, rd.mask}, rd.c1, rd.d1, rd.v1, rd.g};
                    page_mask_out <= {7'b0, rd.mask, 13'b0};
                end
            end else if (state == PROBE) begin
                state     <= RESP;
                index_out <= |probe_vec ? {{(32-IW){1'b0}}, first(probe_vec)} : 32'h8000_0000;
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: scoreboard bench for tlb_unit; stimulus pushes expectations, a negedge monitor pops and compares.
module tb_tlb_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cmd_valid = 1'b0, busy, cmd_done;
    logic [3:0]  cmd_type = '0;
    logic [31:0] cp0_index = '0, cp0_entry_hi = '0, cp0_entry_lo0 = '0, cp0_entry_lo1 = '0;
    logic [31:0] cp0_page_mask = '0, cp0_random = '0;
    logic [31:0] index_out, entry_hi_out, entry_lo0_out, entry_lo1_out, page_mask_out;
    logic [31:0] inst_vaddr = 32'h8000_1000, data_vaddr = 32'h0040_0000;
    logic        data_is_write = 1'b0;
    logic [31:0] inst_paddr, data_paddr;
    logic        inst_refill, inst_invalid, data_refill, data_invalid, data_modify, inst_cached, data_cached;

    tlb_unit #(.TLB_NUM(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .busy(busy), .cmd_done(cmd_done),
        .cp0_index(cp0_index), .cp0_entry_hi(cp0_entry_hi), .cp0_entry_lo0(cp0_entry_lo0),
        .cp0_entry_lo1(cp0_entry_lo1), .cp0_page_mask(cp0_page_mask), .cp0_random(cp0_random),
        .index_out(index_out), .entry_hi_out(entry_hi_out), .entry_lo0_out(entry_lo0_out),
        .entry_lo1_out(entry_lo1_out), .page_mask_out(page_mask_out),
        .inst_vaddr(inst_vaddr), .data_vaddr(data_vaddr), .data_is_write(data_is_write),
        .inst_paddr(inst_paddr), .data_paddr(data_paddr), .inst_refill(inst_refill),
        .inst_invalid(inst_invalid), .data_refill(data_refill), .data_invalid(data_invalid),
        .data_modify(data_modify), .inst_cached(inst_cached), .data_cached(data_cached)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0, errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // fl = {refill, invalid, modify, cached}
    typedef struct { int due; bit d; bit cp; logic [31:0] pa; logic [3:0] fl; } lk_t;
    typedef struct { int due; bit chk; logic [31:0] idx, hi, lo0, lo1; } cm_t;
    lk_t lq[$];
    cm_t cq[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (lq.size() > 0 && lq[0].due <= cyc) begin
            lk_t e;
            e = lq.pop_front();
            if (e.d) begin
                if (e.cp) check("data_paddr", data_paddr, e.pa);
                check("data_flags", {28'b0, data_refill, data_invalid, data_modify, data_cached}, {28'b0, e.fl});
            end else begin
                if (e.cp) check("inst_paddr", inst_paddr, e.pa);
                check("inst_flags", {28'b0, inst_refill, inst_invalid, 1'b0, inst_cached}, {28'b0, e.fl});
            end
        end
        if (cmd_done) begin
            if (cq.size() == 0) check("unexpected_cmd_done", 32'd1, 32'd0);
            else begin
                cm_t c;
                c = cq.pop_front();
                check("cmd_done_cycle", cyc, c.due);
                if (c.chk) begin
                    check("index_out", index_out, c.idx);
                    check("entry_hi_out", entry_hi_out, c.hi);
                    check("entry_lo0_out", entry_lo0_out, c.lo0);
                    check("entry_lo1_out", entry_lo1_out, c.lo1);
                    check("page_mask_out", page_mask_out, 32'h0);
                end
            end
        end else if (cq.size() > 0 && cq[0].due < cyc) begin
            check("missing_cmd_done", 32'd0, 32'd1);
            void'(cq.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_d(logic [31:0] va, logic wr, logic [7:0] asid, bit cp, logic [31:0] pa, logic [3:0] fl);
        data_vaddr = va;
        data_is_write = wr;
        cp0_entry_hi = {24'h0, asid};
        lq.push_back('{cyc + 1, 1'b1, cp, pa, fl});
        tick;
    endtask

    task automatic exp_i(logic [31:0] va, logic [31:0] pa, logic [3:0] fl);
        inst_vaddr = va;
        lq.push_back('{cyc + 1, 1'b0, 1'b1, pa, fl});
        tick;
    endtask

    task automatic cmd(logic [3:0] t, logic [31:0] idx, logic [31:0] rnd, logic [31:0] hi, logic [31:0] lo0,
                       logic [31:0] lo1, bit push, bit chk, logic [31:0] e_idx, logic [31:0] e_hi,
                       logic [31:0] e_lo0, logic [31:0] e_lo1);
        cmd_valid = 1'b1;
        cmd_type = t;
        cp0_index = idx;
        cp0_random = rnd;
        cp0_entry_hi = hi;
        cp0_entry_lo0 = lo0;
        cp0_entry_lo1 = lo1;
        if (push) cq.push_back('{cyc + (t[0] ? 2 : 1), chk, e_idx, e_hi, e_lo0, e_lo1});
        tick;
        cmd_valid = 1'b0;
        cmd_type = '0;
        repeat (3) tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick;
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_cmd_done", {31'b0, cmd_done}, 32'h0);
        check("reset_outs", index_out | entry_hi_out | entry_lo0_out | entry_lo1_out | page_mask_out, 32'h0);
        check("reset_paddr", inst_paddr | data_paddr, 32'h0);
        check("reset_flags", {25'b0, inst_refill, inst_invalid, data_refill, data_invalid, data_modify,
                              inst_cached, data_cached}, 32'h0);
        rst = 1'b1;
        lq.push_back('{cyc + 1, 1'b1, 1'b0, 32'h0, 4'b1000});
        lq.push_back('{cyc + 1, 1'b0, 1'b1, 32'h0000_1000, 4'b0001});
        tick;
        tick;
        // index 0x13 wraps to entry 3
        cmd(4'b0100, 32'h13, 0, 32'h0040_0005, 32'h0000_0106, 32'h0, 1, 0, 0, 0, 0, 0);
        exp_d(32'h0040_0ABC, 0, 8'h05, 1, 32'h0000_4ABC, 4'b0000);
        exp_d(32'h0040_1ABC, 0, 8'h05, 0, 32'h0, 4'b0100);
        cmd(4'b0001, 0, 0, 32'h0040_0005, 0, 0, 1, 1, 32'h3, 0, 0, 0);
        cmd(4'b0001, 0, 0, 32'h0080_0005, 0, 0, 1, 1, 32'h8000_0000, 0, 0, 0);
        cmd(4'b0010, 32'h3, 0, 0, 0, 0, 1, 1, 32'h8000_0000, 32'h0040_0005, 32'h0000_0106, 32'h0);
        exp_i(32'hBFC0_0000, 32'h1FC0_0000, 4'b0000);
        cmd(4'b0100, 32'h3, 0, 32'h0040_0005, 32'h0000_0102, 32'h0, 1, 0, 0, 0, 0, 0);
        exp_d(32'h0040_0000, 1, 8'h05, 0, 32'h0, 4'b0010);
        exp_d(32'h0040_0000, 0, 8'h05, 1, 32'h0000_4000, 4'b0000);
        exp_d(32'h0040_0000, 1, 8'h06, 0, 32'h0, 4'b1000);
        // global entry via TLBWR, random 0x21 wraps to entry 1 and outranks entry 3
        cmd(4'b1000, 0, 32'h21, 32'h0040_0005, 32'h0000_01DF, 32'h0000_0001, 1, 0, 0, 0, 0, 0);
        exp_d(32'h0040_0123, 0, 8'h06, 1, 32'h0000_7123, 4'b0001);
        exp_d(32'h0040_0123, 1, 8'h05, 1, 32'h0000_7123, 4'b0001);
        exp_d(32'h0040_1123, 0, 8'h05, 0, 32'h0, 4'b0100);
        cmd(4'b0001, 0, 0, 32'h0040_0009, 0, 0, 1, 1, 32'h1, 32'h0040_0005, 32'h0000_0106, 32'h0);
        cmd(4'b0010, 32'h1, 0, 0, 0, 0, 1, 1, 32'h1, 32'h0040_0005, 32'h0000_01DF, 32'h0000_0001);
        cmd(4'b0011, 0, 0, 32'h00C0_0000, 32'h0000_0106, 0, 0, 0, 0, 0, 0, 0);
        cmd(4'b1100, 0, 0, 32'h00C0_0000, 32'h0000_0106, 0, 0, 0, 0, 0, 0, 0);
        cmd(4'b0000, 0, 0, 32'h00C0_0000, 32'h0000_0106, 0, 0, 0, 0, 0, 0, 0);
        check("reject_busy", {31'b0, busy}, 32'h0);
        exp_d(32'h00C0_0000, 0, 8'h00, 0, 32'h0, 4'b1000);
        cmd_valid = 1'b1;
        cmd_type = 4'b0001;
        cp0_entry_hi = 32'h0040_0005;
        cq.push_back('{cyc + 2, 1'b1, 32'h1, 32'h0040_0005, 32'h0000_01DF, 32'h0000_0001});
        tick;
        check("probe_busy", {31'b0, busy}, 32'h1);
        cmd_type = 4'b0100;
        cp0_index = 0;
        cp0_entry_hi = 32'h00C0_0000;
        cp0_entry_lo0 = 32'h0000_0106;
        tick;
        tick;
        cmd_valid = 1'b0;
        cmd_type = '0;
        tick;
        exp_d(32'h00C0_0000, 0, 8'h00, 0, 32'h0, 4'b1000);
        cmd_valid = 1'b1;
        cmd_type = 4'b0001;
        cp0_entry_hi = 32'h0040_0005;
        tick;
        cmd_valid = 1'b0;
        cmd_type = '0;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_index", index_out, 32'h0);
        tick;
        tick;
        exp_d(32'h0040_0ABC, 0, 8'h05, 0, 32'h0, 4'b1000);
        cmd(4'b0010, 32'h3, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0);
        cmd(4'b0010, 32'h1, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) tick;
        check("lookup_queue_drained", lq.size(), 32'd0);
        check("cmd_queue_drained", cq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
